// File: rtl/spgd_dac_pkg.sv
// Shared definitions for the SPGD DAC output-conditioning path.
// State encodings, default DAC width and the signed mid-scale code.
package spgd_dac_pkg;

  localparam int unsigned DAC_WIDTH_DEF = 14;
  localparam int unsigned STATE_W       = 1;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RAMP = 1'b1;

  localparam int DAC_MID = 0;

endpackage

// File: rtl/dac_slew_limiter_if.sv
// Control/data bundle for the DAC slew limiter.
// The master drives codes and limits; the slave returns the conditioned DAC code and status.
interface dac_slew_limiter_if #(
  parameter int unsigned DAC_WIDTH  = 14,
  parameter int unsigned STEP_WIDTH = 10,
  parameter int unsigned DIV_WIDTH  = 8
);

  logic signed [DAC_WIDTH-1:0]  code_in;
  logic                         code_valid;
  logic                         enable;
  logic        [STEP_WIDTH-1:0] max_step;
  logic        [DIV_WIDTH-1:0]  tick_div;
  logic signed [DAC_WIDTH-1:0]  code_min;
  logic signed [DAC_WIDTH-1:0]  code_max;
  logic signed [DAC_WIDTH-1:0]  dac_code_out;
  logic                         busy;
  logic                         settled;
  logic                         clamped;

  modport master (
    output code_in, code_valid, enable, max_step, tick_div, code_min, code_max,
    input  dac_code_out, busy, settled, clamped
  );

  modport slave (
    input  code_in, code_valid, enable, max_step, tick_div, code_min, code_max,
    output dac_code_out, busy, settled, clamped
  );

endinterface

// File: rtl/dac_slew_limiter_code_clamp.sv
// Combinational signed window clamp; an inverted window (min > max) resolves to max.
// Shared between the DAC A and DAC B conditioning paths.
module code_clamp #(
  parameter int unsigned W = 14
) (
  input  logic signed [W-1:0] i_code,
  input  logic signed [W-1:0] i_min,
  input  logic signed [W-1:0] i_max,
  output logic signed [W-1:0] o_clamped_c,
  output logic                o_hit_c
);

  always_comb begin
    o_clamped_c = i_code;
    if (i_min > i_max) begin
      o_clamped_c = i_max;
    end else if (i_code < i_min) begin
      o_clamped_c = i_min;
    end else if (i_code > i_max) begin
      o_clamped_c = i_max;
    end
    o_hit_c = (o_clamped_c != i_code);
  end

endmodule

// File: rtl/dac_slew_limiter.sv
// Rate-limited DAC A output stage: clamps each accepted code into a window and
// walks the output toward it by at most MAX_STEP every TICK_DIV+1 cycles.
module dac_slew_limiter
  import spgd_dac_pkg::*;
#(
  parameter int unsigned DAC_WIDTH  = DAC_WIDTH_DEF,
  parameter int unsigned STEP_WIDTH = 10,
  parameter int unsigned DIV_WIDTH  = 8
) (
  input  logic             i_adc_clk,
  input  logic             i_rst,
  dac_slew_limiter_if.slave bus
);

  localparam int unsigned DW1 = DAC_WIDTH + 1;

  logic [STATE_W-1:0]          r_state;
  logic signed [DAC_WIDTH-1:0] r_target;
  logic signed [DAC_WIDTH-1:0] r_out;
  logic [DIV_WIDTH-1:0]        r_cnt;
  logic                        r_busy;
  logic                        r_settled;
  logic                        r_clamped;

  logic [STATE_W-1:0]          w_state_nxt;
  logic signed [DAC_WIDTH-1:0] w_target_nxt;
  logic signed [DAC_WIDTH-1:0] w_out_nxt;
  logic [DIV_WIDTH-1:0]        w_cnt_nxt;
  logic                        w_clamped_nxt;
  logic signed [DAC_WIDTH-1:0] w_clamp_code;
  logic                        w_clamp_hit;
  logic signed [DW1-1:0]       w_diff;
  logic [DW1-1:0]              w_abs;
  logic [DW1-1:0]              w_step;
  logic signed [DAC_WIDTH-1:0] w_stepped;

  code_clamp #(.W(DAC_WIDTH)) u_clamp (
    .i_code      (bus.code_in),
    .i_min       (bus.code_min),
    .i_max       (bus.code_max),
    .o_clamped_c (w_clamp_code),
    .o_hit_c     (w_clamp_hit)
  );

  // Step toward the newest target so an ENABLE drop or retarget steers the very same edge.
  always_comb begin
    w_state_nxt   = r_state;
    w_target_nxt  = r_target;
    w_out_nxt     = r_out;
    w_cnt_nxt     = r_cnt;
    w_clamped_nxt = r_clamped;
    w_diff        = '0;
    w_abs         = '0;
    w_step        = DW1'(bus.max_step);
    w_stepped     = r_out;

    if (!bus.enable) begin
      w_target_nxt  = DAC_WIDTH'(DAC_MID);
      w_clamped_nxt = 1'b0;
    end else if (bus.code_valid) begin
      w_target_nxt  = w_clamp_code;
      w_clamped_nxt = w_clamp_hit;
    end

    w_diff = $signed({w_target_nxt[DAC_WIDTH-1], w_target_nxt})
           - $signed({r_out[DAC_WIDTH-1], r_out});
    w_abs  = w_diff[DW1-1] ? DW1'(-w_diff) : DW1'(w_diff);

    if ((bus.max_step == '0) || (w_abs <= w_step)) begin
      w_stepped = w_target_nxt;
    end else if (w_diff[DW1-1]) begin
      w_stepped = r_out - DAC_WIDTH'(bus.max_step);
    end else begin
      w_stepped = r_out + DAC_WIDTH'(bus.max_step);
    end

    case (r_state)
      ST_IDLE: begin
        w_cnt_nxt = '0;
        if (w_target_nxt != r_out) begin
          w_state_nxt = ST_RAMP;
        end
      end
      ST_RAMP: begin
        if (r_cnt == bus.tick_div) begin
          w_out_nxt = w_stepped;
          w_cnt_nxt = '0;
        end else begin
          w_cnt_nxt = DIV_WIDTH'(r_cnt + 1'b1);
        end
        if (w_out_nxt == w_target_nxt) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge i_adc_clk) begin
    if (i_rst) begin
      r_state   <= ST_IDLE;
      r_target  <= '0;
      r_out     <= '0;
      r_cnt     <= '0;
      r_busy    <= 1'b0;
      r_settled <= 1'b1;
      r_clamped <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_target  <= w_target_nxt;
      r_out     <= w_out_nxt;
      r_cnt     <= w_cnt_nxt;
      r_busy    <= (w_state_nxt == ST_RAMP);
      r_settled <= (w_out_nxt == w_target_nxt);
      r_clamped <= w_clamped_nxt;
    end
  end

  assign bus.dac_code_out = r_out;
  assign bus.busy         = r_busy;
  assign bus.settled      = r_settled;
  assign bus.clamped      = r_clamped;

endmodule

// File: tb/tb_dac_slew_limiter.sv
// Directed bench for dac_slew_limiter: ramp timing, clamp, retarget, enable park, reset.
module tb_dac_slew_limiter;

  logic clk = 1'b0;
  logic rst;
  int   n_pass  = 0;
  int   n_total = 0;

  always #5 clk = ~clk;

  dac_slew_limiter_if #(.DAC_WIDTH(14), .STEP_WIDTH(10), .DIV_WIDTH(8)) bus ();

  dac_slew_limiter #(.DAC_WIDTH(14), .STEP_WIDTH(10), .DIV_WIDTH(8)) u_dut (
    .i_adc_clk (clk),
    .i_rst     (rst),
    .bus       (bus)
  );

  task automatic step_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic park_zero();
    bit done = 0;
    bus.enable   = 1'b0;
    bus.max_step = '0;
    bus.tick_div = '0;
    for (int i = 0; i < 8 && !done; i++) begin
      step_edge();
      if (bus.dac_code_out == 14'(0) && bus.settled) done = 1;
    end
    n_total++;
    if (!done) $display("FAIL park_zero: out=%0d settled=%b want 0/1", bus.dac_code_out, bus.settled);
    else n_pass++;
    bus.enable   = 1'b1;
    bus.code_min = 14'(-8192);
    bus.code_max = 14'(8191);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step_edge();
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step_edge();
      n_total++;
      if ({bus.dac_code_out, bus.busy, bus.settled, bus.clamped} !== {14'd0, 3'b010})
        $display("FAIL reset_idle cyc %0d: out=%0d busy=%b settled=%b clamped=%b want 0/0/1/0",
                 i, bus.dac_code_out, bus.busy, bus.settled, bus.clamped);
      else n_pass++;
    end
  endtask

  task automatic test_ramp_basic();
    int exp_out[4] = '{100, 200, 300, 350};
    bit exp_bsy[4] = '{1, 1, 1, 0};
    bus.max_step = 10'd100;
    bus.tick_div = 8'd0;
    bus.code_in  = 14'(350);
    bus.code_valid = 1'b1;
    step_edge();
    bus.code_valid = 1'b0;
    n_total++;
    if ({bus.dac_code_out, bus.busy, bus.settled} !== {14'd0, 2'b10})
      $display("FAIL ramp_edge1: out=%0d busy=%b settled=%b want 0/1/0",
               bus.dac_code_out, bus.busy, bus.settled);
    else n_pass++;
    for (int i = 0; i < 4; i++) begin
      step_edge();
      n_total++;
      if (bus.dac_code_out !== 14'(exp_out[i]) || bus.busy !== exp_bsy[i] || bus.settled !== !exp_bsy[i])
        $display("FAIL ramp_edge%0d: out=%0d busy=%b settled=%b want %0d/%b/%b",
                 i + 2, bus.dac_code_out, bus.busy, bus.settled, exp_out[i], exp_bsy[i], !exp_bsy[i]);
      else n_pass++;
    end
    n_total++;
    if (bus.clamped !== 1'b0) $display("FAIL ramp_clamped: got %b want 0", bus.clamped);
    else n_pass++;
  endtask

  task automatic test_jump_clamp();
    bus.code_min = 14'(-4000);
    bus.max_step = 10'd0;
    bus.tick_div = 8'd3;
    bus.code_in  = 14'(-8192);
    bus.code_valid = 1'b1;
    step_edge();
    bus.code_valid = 1'b0;
    n_total++;
    if ({bus.dac_code_out, bus.busy, bus.clamped} !== {14'(350), 2'b11})
      $display("FAIL jump_edge1: out=%0d busy=%b clamped=%b want 350/1/1",
               bus.dac_code_out, bus.busy, bus.clamped);
    else n_pass++;
    for (int e = 2; e <= 4; e++) begin
      step_edge();
      n_total++;
      if (bus.dac_code_out !== 14'(350)) $display("FAIL jump_hold edge%0d: out=%0d want 350", e, bus.dac_code_out);
      else n_pass++;
    end
    step_edge();
    n_total++;
    if ({bus.dac_code_out, bus.busy, bus.settled, bus.clamped} !== {14'(-4000), 3'b011})
      $display("FAIL jump_edge5: out=%0d busy=%b settled=%b clamped=%b want -4000/0/1/1",
               bus.dac_code_out, bus.busy, bus.settled, bus.clamped);
    else n_pass++;
  endtask

  task automatic test_reversal();
    int up[8]   = '{0, 64, 64, 128, 128, 192, 192, 256};
    int down[6] = '{256, 192, 192, 128, 128, 100};
    park_zero();
    bus.max_step = 10'd64;
    bus.tick_div = 8'd1;
    bus.code_in  = 14'(1000);
    bus.code_valid = 1'b1;
    step_edge();
    bus.code_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step_edge();
      n_total++;
      if (bus.dac_code_out !== 14'(up[i]))
        $display("FAIL reversal_up edge%0d: out=%0d want %0d", i + 2, bus.dac_code_out, up[i]);
      else n_pass++;
    end
    bus.code_in = 14'(100);
    bus.code_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step_edge();
      bus.code_valid = 1'b0;
      n_total++;
      if (bus.dac_code_out !== 14'(down[i]) || bus.busy !== (i != 5))
        $display("FAIL reversal_down edge%0d: out=%0d busy=%b want %0d/%b",
                 i + 10, bus.dac_code_out, bus.busy, down[i], i != 5);
      else n_pass++;
    end
    n_total++;
    if (bus.settled !== 1'b1) $display("FAIL reversal_settled: got %b want 1", bus.settled);
    else n_pass++;
  endtask

  task automatic test_enable_drop();
    int up[6]   = '{0, 100, 200, 300, 400, 500};
    int down[3] = '{300, 100, 0};
    park_zero();
    bus.max_step = 10'd100;
    bus.tick_div = 8'd0;
    bus.code_in  = 14'(1000);
    bus.code_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step_edge();
      bus.code_valid = 1'b0;
      n_total++;
      if (bus.dac_code_out !== 14'(up[i]))
        $display("FAIL enable_up edge%0d: out=%0d want %0d", i + 1, bus.dac_code_out, up[i]);
      else n_pass++;
    end
    bus.enable     = 1'b0;
    bus.code_valid = 1'b1;
    bus.code_in    = 14'(800);
    bus.max_step   = 10'd200;
    for (int i = 0; i < 3; i++) begin
      step_edge();
      bus.code_valid = 1'b0;
      n_total++;
      if (bus.dac_code_out !== 14'(down[i]) || bus.clamped !== 1'b0)
        $display("FAIL enable_park step%0d: out=%0d clamped=%b want %0d/0",
                 i, bus.dac_code_out, bus.clamped, down[i]);
      else n_pass++;
    end
    step_edge();
    n_total++;
    if ({bus.dac_code_out, bus.busy, bus.settled} !== {14'd0, 2'b01})
      $display("FAIL enable_parked: out=%0d busy=%b settled=%b want 0/0/1",
               bus.dac_code_out, bus.busy, bus.settled);
    else n_pass++;
    bus.enable = 1'b1;
  endtask

  task automatic test_reset_mid();
    int dn[4] = '{0, -100, -200, -300};
    park_zero();
    bus.max_step = 10'd100;
    bus.tick_div = 8'd0;
    bus.code_in  = 14'(-1000);
    bus.code_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step_edge();
      bus.code_valid = 1'b0;
      n_total++;
      if (bus.dac_code_out !== 14'(dn[i]))
        $display("FAIL rstmid_ramp edge%0d: out=%0d want %0d", i + 1, bus.dac_code_out, dn[i]);
      else n_pass++;
    end
    rst = 1'b1;
    step_edge();
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      n_total++;
      if ({bus.dac_code_out, bus.busy, bus.settled, bus.clamped} !== {14'd0, 3'b010})
        $display("FAIL rstmid_state cyc%0d: out=%0d busy=%b settled=%b clamped=%b want 0/0/1/0",
                 i, bus.dac_code_out, bus.busy, bus.settled, bus.clamped);
      else n_pass++;
      step_edge();
    end
    bus.code_in = 14'(50);
    bus.code_valid = 1'b1;
    step_edge();
    bus.code_valid = 1'b0;
    n_total++;
    if ({bus.dac_code_out, bus.busy} !== {14'd0, 1'b1})
      $display("FAIL rstmid_restart1: out=%0d busy=%b want 0/1", bus.dac_code_out, bus.busy);
    else n_pass++;
    step_edge();
    n_total++;
    if ({bus.dac_code_out, bus.busy, bus.settled} !== {14'(50), 2'b01})
      $display("FAIL rstmid_restart2: out=%0d busy=%b settled=%b want 50/0/1",
               bus.dac_code_out, bus.busy, bus.settled);
    else n_pass++;
  endtask

  task automatic test_same_target();
    bus.code_in = 14'(50);
    bus.code_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step_edge();
      bus.code_valid = 1'b0;
      n_total++;
      if ({bus.dac_code_out, bus.busy, bus.settled} !== {14'(50), 2'b01})
        $display("FAIL same_target cyc%0d: out=%0d busy=%b settled=%b want 50/0/1",
                 i, bus.dac_code_out, bus.busy, bus.settled);
      else n_pass++;
    end
  endtask

  task automatic test_inverted_window();
    bus.code_min = 14'(500);
    bus.code_max = 14'(200);
    bus.max_step = 10'd0;
    bus.tick_div = 8'd0;
    bus.code_in  = 14'(0);
    bus.code_valid = 1'b1;
    step_edge();
    bus.code_valid = 1'b0;
    n_total++;
    if ({bus.dac_code_out, bus.busy, bus.clamped} !== {14'(50), 2'b11})
      $display("FAIL inv_window1: out=%0d busy=%b clamped=%b want 50/1/1",
               bus.dac_code_out, bus.busy, bus.clamped);
    else n_pass++;
    step_edge();
    n_total++;
    if ({bus.dac_code_out, bus.busy, bus.settled} !== {14'(200), 2'b01})
      $display("FAIL inv_window2: out=%0d busy=%b settled=%b want 200/0/1",
               bus.dac_code_out, bus.busy, bus.settled);
    else n_pass++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst            = 1'b1;
    bus.code_in    = '0;
    bus.code_valid = 1'b0;
    bus.enable     = 1'b1;
    bus.max_step   = '0;
    bus.tick_div   = '0;
    bus.code_min   = 14'(-8192);
    bus.code_max   = 14'(8191);
    test_reset();
    test_ramp_basic();
    test_jump_clamp();
    test_reversal();
    test_enable_drop();
    test_reset_mid();
    test_same_target();
    test_inverted_window();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/dac_slew_limiter.md
# dac_slew_limiter

Output-conditioning stage directly downstream of the ADC-to-DAC scaling loop. It accepts each new two's-complement DAC code, clamps it to a programmable window, and walks the DAC A output register toward it at a bounded rate. This prevents the 1024-sample averaging cadence from producing full-scale DAC steps that would disturb the SPGD actuator. Enable-low parks the output at mid-scale (code 0) by ramping, never by jumping.

## Interface
- DAC_WIDTH, 14, width of DAC codes in two's complement
- STEP_WIDTH, 10, width of the maximum-step magnitude
- DIV_WIDTH, 8, width of the step-tick divider
- Reset is synchronous and active-high; one clock, ADC_CLK.
- ADC_CLK  in  1  sole clock; all state updates on its rising edge
- RST  in  1  synchronous active-high reset
- CODE_IN  in  DAC_WIDTH  new target code, signed
- CODE_VALID  in  1  one-cycle strobe; CODE_IN is sampled when this is high
- ENABLE  in  1  high = track CODE_IN; low = target forced to 0
- MAX_STEP  in  STEP_WIDTH  unsigned maximum change per tick; 0 = unlimited (jump)
- TICK_DIV  in  DIV_WIDTH  a step occurs every TICK_DIV+1 cycles while ramping
- CODE_MIN  in  DAC_WIDTH  signed lower clamp
- CODE_MAX  in  DAC_WIDTH  signed upper clamp
- DAC_CODE_OUT  out  DAC_WIDTH  registered output code; reset 0
- BUSY  out  1  state is RAMP; reset 0
- SETTLED  out  1  DAC_CODE_OUT equals target; reset 1
- CLAMPED  out  1  last accepted code was altered by the clamp; reset 0

## Operation
- States: IDLE (output == target) and RAMP (output != target).
- Target update, on any edge where CODE_VALID=1 and ENABLE=1:
  - target <= clamp(CODE_IN).
  - CLAMPED <= 1 if the clamp changed the value, else 0.
- Clamp rules:
  - Below CODE_MIN → CODE_MIN; above CODE_MAX → CODE_MAX.
  - If CODE_MIN > CODE_MAX, the result is CODE_MAX.
- ENABLE low: target <= 0 on every edge, CODE_VALID is ignored, and CLAMPED <= 0.
- Step computation:
  - diff = target − DAC_CODE_OUT, computed at DAC_WIDTH+1 bits signed.
  - If MAX_STEP = 0 or |diff| ≤ MAX_STEP: output <= target.
  - Otherwise: output <= output ± MAX_STEP, in the sign of diff.
  - The output can never leave the signed DAC_WIDTH range.
- Tick counter:
  - Cleared on entry to RAMP.
  - Increments each cycle in RAMP.
  - When it equals TICK_DIV, a step is applied and the counter clears.
- Transitions:
  - IDLE→RAMP on the edge where the new target differs from the output.
  - RAMP→IDLE on the edge where the applied step makes output == target.
  - SETTLED rises on that same edge.
- New target mid-ramp: the target is replaced, the tick counter is not reset, and the direction is recomputed on the next step. A target equal to the current output returns to IDLE on that edge.
- A target equal to the output while IDLE: stays IDLE, BUSY never asserts.
- MAX_STEP, TICK_DIV, CODE_MIN and CODE_MAX are sampled live; changes take effect on the next tick or next accepted code.

## Timing
- Counting the edge that samples CODE_VALID as edge 1:
  - BUSY=1 and SETTLED=0 after edge 1.
  - The first output change occurs at edge TICK_DIV+2.
  - Each subsequent step follows TICK_DIV+1 edges later.
- The number of steps to settle is ceil(|diff|/MAX_STEP).
- Simultaneous ENABLE falling and CODE_VALID: ENABLE wins, and the target becomes 0.
- RST mid-ramp: on the next edge all outputs take their reset values, the target and counter clear to 0, and the state becomes IDLE. There is no ramp to zero on reset.
- The outputs have no combinational path from the inputs.

## Structure
- Shared package/header spgd_dac_pkg holds:
  - the state encodings (IDLE=0, RAMP=1)
  - the DAC_WIDTH default
  - the signed mid-scale constant 0
- One combinational sub-module, code_clamp (CODE_IN, CODE_MIN, CODE_MAX → clamped, hit). It is reused later for DAC B.
- Top level: target register, tick counter, step arithmetic, state register.

## Test plan
- Reset then idle → DAC_CODE_OUT=0, SETTLED=1, BUSY=0, CLAMPED=0 for 20 cycles.
- MAX_STEP=100, TICK_DIV=0, CODE_IN=350:
  - Output follows 0→100→200→300→350 on edges 2–5.
  - BUSY falls and SETTLED rises at edge 5.
- MAX_STEP=0, TICK_DIV=3, CODE_IN=−8192 with CODE_MIN=−4000 → output jumps to −4000 at edge 5, CLAMPED=1.
- Mid-ramp reversal: ramp 0→1000 with MAX_STEP=64, TICK_DIV=1. After output=256, apply CODE_IN=100 → next steps are 192, then 128, then 100, settling.
- ENABLE drops at output=500 with a simultaneous CODE_VALID of 800, MAX_STEP=200, TICK_DIV=0 → output goes 300, 100, 0; CODE_IN is ignored.
- RST asserted mid-ramp at output=−300 → DAC_CODE_OUT=0, BUSY=0, SETTLED=1 one edge later. A subsequent CODE_IN=50 ramps from 0.
